// File: rtl/task3_prog_loader.sv
// rtl/task3_prog_loader.sv - instruction memory loader: header/program/checksum stream into CPU instruction RAM
//
// Purpose: accepts a byte stream (length N, N program bytes, 8-bit additive checksum)
//   over a valid/ready handshake and writes the program bytes into the instruction RAM.
//   The CPU is held until a load completes with a matching checksum. A bad header or a
//   bad checksum parks the loader in an error state with the CPU still held.
// Optional feature: define TASK3_LOADER_ZERO_FILL_EN to pad addresses N..DEPTH-1 with
//   8'h00 (NOP) after a good checksum, before the CPU is released.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_valid/s_data      input byte stream; s_ready is the loader's accept (Moore)
//   reload              1-cycle pulse, restarts a load from RUN or ERR
//   mem_we/mem_addr/
//   mem_wdata           registered instruction memory write port
//   cpu_hold            1 = CPU held in reset
//   done / err          load verified / load failed
//   count               program bytes written in the current load
module task3_prog_loader #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CSUM,
    S_FILL,
    S_RUN,
    S_ERR
  } state_t;

`ifdef TASK3_LOADER_ZERO_FILL_EN
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
`endif

  state_t            state, state_nx;
  logic [ADDR_W:0]   len, len_nx;
  // One bit wider than mem_addr so it can hold N == DEPTH after the last byte.
  logic [ADDR_W:0]   addr, addr_nx;
  logic [ADDR_W:0]   count_nx;
  logic [DATA_W-1:0] sum, sum_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] maddr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic              take;

  // Status outputs are decoded from the state so they are valid the cycle after the
  // transition and need no separate reset handling.
  assign s_ready  = (state == S_IDLE) || (state == S_LOAD) || (state == S_CSUM);
  assign done     = (state == S_RUN);
  assign err      = (state == S_ERR);
  assign cpu_hold = (state != S_RUN);
  assign take     = s_valid && s_ready;

  always_comb begin
    state_nx = state;
    len_nx   = len;
    addr_nx  = addr;
    count_nx = count;
    sum_nx   = sum;
    we_nx    = 1'b0;
    maddr_nx = mem_addr;
    wdata_nx = mem_wdata;
    case (state)
      S_IDLE: begin
        if (take) begin
          if ((s_data == '0) || (s_data > DATA_W'(DEPTH))) begin
            state_nx = S_ERR;
          end else begin
            len_nx   = s_data[ADDR_W:0];
            addr_nx  = '0;
            sum_nx   = '0;
            count_nx = '0;
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (take) begin
          we_nx    = 1'b1;
          maddr_nx = addr[ADDR_W-1:0];
          wdata_nx = s_data;
          addr_nx  = addr + 1'b1;
          count_nx = count + 1'b1;
          sum_nx   = sum + s_data;
          if ((addr + 1'b1) == len) begin
            state_nx = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (take) begin
          if (s_data == sum) begin
`ifdef TASK3_LOADER_ZERO_FILL_EN
            state_nx = (len < DEPTH_C) ? S_FILL : S_RUN;
`else
            state_nx = S_RUN;
`endif
          end else begin
            state_nx = S_ERR;
          end
        end
      end
`ifdef TASK3_LOADER_ZERO_FILL_EN
      S_FILL: begin
        // addr already points at N; pad one NOP per cycle up to the top address.
        we_nx    = 1'b1;
        maddr_nx = addr[ADDR_W-1:0];
        wdata_nx = '0;
        addr_nx  = addr + 1'b1;
        if (addr == (DEPTH_C - 1'b1)) begin
          state_nx = S_RUN;
        end
      end
`endif
      S_RUN, S_ERR: begin
        if (reload) begin
          state_nx = S_IDLE;
          count_nx = '0;
          sum_nx   = '0;
        end
      end
      default: begin
        state_nx = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      addr      <= '0;
      count     <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      len       <= len_nx;
      addr      <= addr_nx;
      count     <= count_nx;
      sum       <= sum_nx;
      mem_we    <= we_nx;
      mem_addr  <= maddr_nx;
      mem_wdata <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_task3_prog_loader.sv
// tb/tb_task3_prog_loader.sv - scoreboard bench for task3_prog_loader
`timescale 1ns/1ps
module tb_task3_prog_loader;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              reload = 1'b0;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  task3_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [ADDR_W+DATA_W-1:0] sb[$];
  logic [7:0] prog[$];
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every write the DUT issues must match the oldest expected (addr, data) pair.
  always @(negedge clk) begin
    if (mon_en && mem_we !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexp_wr", 32'({mem_addr, mem_wdata}), 32'h7ff_ffff);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = sb.pop_front();
        check("wr", 32'({mem_addr, mem_wdata}), 32'(e));
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic reload_pulse();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("rl_err", 32'(err), 32'd0);
    check("rl_done", 32'(done), 32'd0);
    check("rl_hold", 32'(cpu_hold), 32'd1);
    check("rl_count", 32'(count), 32'd0);
    check("rl_ready", 32'(s_ready), 32'd1);
  endtask

  // Streams header, prog[] and csum; good says whether csum is the correct sum.
  task automatic load_prog(input logic [7:0] csum, input bit good, input bit gaps);
    int n;
    int cyc;
    int exp_lat;
    n = prog.size();
    exp_lat = 0;
    send(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      sb.push_back({3'(i), prog[i]});
      send(prog[i], gaps);
    end
`ifdef TASK3_LOADER_ZERO_FILL_EN
    if (good) begin
      for (int i = n; i < DEPTH; i++) sb.push_back({3'(i), 8'h00});
      exp_lat = DEPTH - n;
    end
`endif
    send(csum, gaps);
    if (good) begin
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("done_lat", 32'(cyc), 32'(exp_lat));
      check("run_done", 32'(done), 32'd1);
      check("run_hold", 32'(cpu_hold), 32'd0);
      check("run_err", 32'(err), 32'd0);
      check("run_ready", 32'(s_ready), 32'd0);
      check("run_count", 32'(count), 32'(n));
    end else begin
      check("bad_err", 32'(err), 32'd1);
      check("bad_done", 32'(done), 32'd0);
      check("bad_hold", 32'(cpu_hold), 32'd1);
      check("bad_ready", 32'(s_ready), 32'd0);
      check("bad_count", 32'(count), 32'(n));
    end
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Straight load, no gaps.
    prog = '{8'hC0, 8'hD1, 8'h49, 8'h58, 8'h00};
    load_prog(8'h32, 1'b1, 1'b0);

    // Wrong checksum, then recover.
    reload_pulse();
    load_prog(8'h33, 1'b0, 1'b0);
    reload_pulse();

    // Header out of range: zero and above DEPTH.
    send(8'h00, 1'b0);
    check("hdr0_err", 32'(err), 32'd1);
    check("hdr0_hold", 32'(cpu_hold), 32'd1);
    check("hdr0_count", 32'(count), 32'd0);
    reload_pulse();
    send(8'h09, 1'b0);
    check("hdr9_err", 32'(err), 32'd1);
    check("hdr9_ready", 32'(s_ready), 32'd0);
    reload_pulse();

    // Same program with random valid gaps.
    for (int r = 0; r < 3; r++) begin
      load_prog(8'h32, 1'b1, 1'b1);
      reload_pulse();
    end

    // Reset asserted in the cycle the 2nd program byte is offered: that write is dropped.
    send(8'h05, 1'b0);
    sb.push_back({3'd0, 8'hC0});
    send(8'hC0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hD1;
    rst_n   = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    check_reset_vals();
    check("rst_sb", 32'(sb.size()), 32'd0);
    load_prog(8'h32, 1'b1, 1'b0);

    // Short program: zero fill (when enabled) pads addresses 3..7.
    reload_pulse();
    prog = '{8'hC0, 8'hD1, 8'h49};
    load_prog(8'hDA, 1'b1, 1'b0);

    // reload outside RUN/ERR is ignored.
    reload_pulse();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("idle_reload_ready", 32'(s_ready), 32'd1);
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    load_prog(8'h64, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
